// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_pkg
//  Brief    : Shared types, constants and operand classifiers for the FP32
//             multiplier/divider pair.
//  Revision : 1.0 - initial release
// ============================================================================
package fp32_pkg;

   // Field widths of an IEEE-754 single-precision word
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;   // significand with hidden one

   // Quotient bits produced: 24 significand + 1 normalization + 1 spare
   localparam int ITER  = 26;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   // Exponent arithmetic runs in 10-bit signed to catch overflow/underflow
   localparam int EXPC_W = 10;
   localparam logic signed [EXPC_W-1:0] BIAS    = 10'sd127;
   localparam logic signed [EXPC_W-1:0] EXP_MAX = 10'sd255;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHECK     = 3'd1,
      ST_DIVIDE    = 3'd2,
      ST_NORMALIZE = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   typedef struct packed {
      logic nan;
      logic inf;
      logic ovf;
      logic unf;
      logic dz;
   } fp_flags_t;

   // Exponent all-ones with nonzero fraction
   function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
      return (e == '1) && (f != '0);
   endfunction

   // Exponent all-ones with zero fraction
   function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
      return (e == '1) && (f == '0);
   endfunction

   // Exponent zero: true zero or denormal, both treated as zero
   function automatic logic is_zero(input logic [EXP_W-1:0] e);
      return (e == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_mant_divider.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_mant_divider
//  Brief    : Restoring radix-2 significand divider, one quotient bit per
//             step. q[ITER-1] carries weight 2^0.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_mant_divider
   import fp32_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [MANT_W-1:0] i_ma,
   input  logic [MANT_W-1:0] i_mb,
   output logic [ITER-1:0]   o_q
);

   // Remainder needs one extra bit: after the shift it may reach 2*mb - 1
   logic [MANT_W:0]   r_rem;
   logic [MANT_W-1:0] r_mb;
   logic [ITER-1:0]   r_q;

   logic              w_ge;
   logic [MANT_W-1:0] w_rem_next;

   // Trial subtraction; a successful difference is below mb so fits 24 bits
   always_comb begin
      w_ge       = (r_rem >= {1'b0, r_mb});
      w_rem_next = r_rem[MANT_W-1:0];
      if (w_ge) begin
         w_rem_next = r_rem[MANT_W-1:0] - r_mb;
      end
   end

   // Load operands, then shift one quotient bit in per step
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= '0;
         r_mb  <= '0;
         r_q   <= '0;
      end else if (i_load) begin
         r_rem <= {1'b0, i_ma};
         r_mb  <= i_mb;
         r_q   <= '0;
      end else if (i_step) begin
         r_rem <= {w_rem_next, 1'b0};
         r_q   <= {r_q[ITER-2:0], w_ge};
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fp32_divider.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_divider
//  Brief    : Iterative IEEE-754 single-precision divider. Special operands
//             resolve in CHECK; finite operands take a fixed 29-cycle path
//             through the restoring significand core. Truncating, denormals
//             flushed to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_divider
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] quotient_o,
   output logic        done_o,
   output logic        busy_o,
   output logic        nan_o,
   output logic        infinit_o,
   output logic        overflow_o,
   output logic        underflow_o,
   output logic        div_zero_o
);

   state_t                   r_state;
   state_t                   w_state_next;

   logic [31:0]              r_a;
   logic [31:0]              r_b;
   logic signed [EXPC_W-1:0] r_exp;
   logic [CNT_W-1:0]         r_cnt;
   logic [31:0]              r_quot;
   fp_flags_t                r_flags;
   logic                     r_done;

   logic                     w_load;
   logic                     w_step;
   logic [ITER-1:0]          w_q;

   // Operand classification of the captured words
   logic w_sign;
   logic w_a_nan, w_a_inf, w_a_zero;
   logic w_b_nan, w_b_inf, w_b_zero;

   assign w_sign   = r_a[31] ^ r_b[31];
   assign w_a_nan  = is_nan(r_a[30:23], r_a[22:0]);
   assign w_a_inf  = is_inf(r_a[30:23], r_a[22:0]);
   assign w_a_zero = is_zero(r_a[30:23]);
   assign w_b_nan  = is_nan(r_b[30:23], r_b[22:0]);
   assign w_b_inf  = is_inf(r_b[30:23], r_b[22:0]);
   assign w_b_zero = is_zero(r_b[30:23]);

   logic                     w_special;
   logic [31:0]              w_spec_q;
   fp_flags_t                w_spec_flags;
   logic signed [EXPC_W-1:0] w_exp_init;

   // Special-operand resolution in priority order; sign applies to all but NaN
   always_comb begin
      w_special    = 1'b1;
      w_spec_q     = '0;
      w_spec_flags = '0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_q         = QNAN;
         w_spec_flags.nan = 1'b1;
         w_spec_flags.inf = w_a_inf && w_b_inf;
      end else if (w_a_inf) begin
         w_spec_q         = POS_INF | {w_sign, 31'b0};
         w_spec_flags.inf = 1'b1;
      end else if (w_b_inf) begin
         w_spec_q         = {w_sign, 31'b0};
         w_spec_flags.inf = 1'b1;
      end else if (w_b_zero) begin
         w_spec_q        = POS_INF | {w_sign, 31'b0};
         w_spec_flags.dz = 1'b1;
      end else if (w_a_zero) begin
         w_spec_q = {w_sign, 31'b0};
      end else begin
         w_special = 1'b0;
      end
      w_exp_init = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + BIAS;
   end

   logic                     w_shift;
   logic [FRAC_W-1:0]        w_frac;
   logic signed [EXPC_W-1:0] w_exp_n;
   logic [31:0]              w_norm_q;
   fp_flags_t                w_norm_flags;

   // Normalize: a quotient below 1.0 shifts left once; then range-check exponent
   always_comb begin
      w_shift      = ~w_q[ITER-1];
      w_frac       = w_shift ? w_q[ITER-3:1] : w_q[ITER-2:2];
      w_exp_n      = w_shift ? (r_exp - 10'sd1) : r_exp;
      w_norm_flags = '0;
      if (w_exp_n >= EXP_MAX) begin
         w_norm_q         = POS_INF | {w_sign, 31'b0};
         w_norm_flags.ovf = 1'b1;
      end else if (w_exp_n <= 10'sd0) begin
         w_norm_q         = {w_sign, 31'b0};
         w_norm_flags.unf = 1'b1;
      end else begin
         w_norm_q = {w_sign, w_exp_n[EXP_W-1:0], w_frac};
      end
   end

   // Bits that never reach the result: truncated LSB and exponent headroom
   logic w_unused_bits;
   assign w_unused_bits = &{1'b0, w_q[0], w_exp_n[EXPC_W-1:EXP_W]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and core control
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_special) begin
               w_state_next = ST_DONE;
            end else begin
               w_load       = 1'b1;
               w_state_next = ST_DIVIDE;
            end
         end
         ST_DIVIDE: begin
            w_step = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_next = ST_NORMALIZE;
            end
         end
         ST_NORMALIZE: begin
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Operand capture, step counting, and result/flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_exp   <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_flags <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= (w_state_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_a     <= a_i;
                  r_b     <= b_i;
                  r_quot  <= '0;
                  r_flags <= '0;
               end
            end
            ST_CHECK: begin
               r_cnt <= '0;
               r_exp <= w_exp_init;
               if (w_special) begin
                  r_quot  <= w_spec_q;
                  r_flags <= w_spec_flags;
               end
            end
            ST_DIVIDE: begin
               r_cnt <= r_cnt + 1'b1;
            end
            ST_NORMALIZE: begin
               r_quot  <= w_norm_q;
               r_flags <= w_norm_flags;
            end
            default: begin
            end
         endcase
      end
   end

   fp32_mant_divider u_mant_div (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_step (w_step),
      .i_ma   ({1'b1, r_a[22:0]}),
      .i_mb   ({1'b1, r_b[22:0]}),
      .o_q    (w_q)
   );

   assign quotient_o  = r_quot;
   assign done_o      = r_done;
   assign busy_o      = (r_state != ST_IDLE);
   assign nan_o       = r_flags.nan;
   assign infinit_o   = r_flags.inf;
   assign overflow_o  = r_flags.ovf;
   assign underflow_o = r_flags.unf;
   assign div_zero_o  = r_flags.dz;

endmodule
`default_nettype wire
